// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encodings, frame width and default bit divisor.
package uart_receiver_pkg;

  localparam int            UART_DATA_BITS    = 8;
  localparam int            UART_TIMER_W      = 14;
  localparam logic [13:0]   UART_BAUD_DEFAULT = 14'd20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_bit_timer.sv
// Bit-period timer for the UART receiver: 14-bit down-counter, tick while at zero.
module uart_rx_bit_timer
  import uart_receiver_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [UART_TIMER_W-1:0] load_val,
  output logic                    tick
);

  logic [UART_TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity_err pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, confirm start bit still low
// DATA   | sample 8 data bits LSB-first, one per bit period
// PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sample stop bit, publish byte or flag framing error
// BREAK  | line stuck low after bad stop, wait for high
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter logic [13:0] BAUD_RATE_NUMBER = UART_BAUD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       rx_busy
);

  localparam logic [13:0] HALF_BIT = BAUD_RATE_NUMBER >> 1;

  rx_state_e                 state_q, state_d;
  logic                      rx_meta_q, rx_s_q;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      tmr_load, tmr_tick;
  logic [13:0]               tmr_val;
`ifdef UART_RX_PARITY_EN
  logic                      pbad_q, pbad_d;
  logic                      perr_q, perr_d;
`endif

  uart_rx_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tmr_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = BAUD_RATE_NUMBER;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    perr_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_BIT;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (tmr_tick) begin
          if (!rx_s_q) begin
            tmr_load = 1'b1;
            idx_d    = 3'd0;
            state_d  = ST_DATA;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tmr_tick) begin
          shift_d  = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          tmr_load = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tmr_tick) begin
          pbad_d   = (^shift_q) ^ rx_s_q;
          tmr_load = 1'b1;
          state_d  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tmr_tick) begin
          data_d = shift_q;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            valid_d = !pbad_q;
            perr_d  = pbad_q;
`else
            valid_d = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            // frame error outranks parity error
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      shift_q   <= '0;
      idx_q     <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q    <= pbad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: behavioural serializer at 21 clks/bit plus pulse monitors.
module tb_uart_receiver;

  localparam int BIT_CLKS = 21;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  int wide_cnt  = 0;
  int excl_cnt  = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;
  logic cur_perr;

  uart_receiver #(.BAUD_RATE_NUMBER(14'd20)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  assign cur_perr = parity_err;
`else
  assign cur_perr = 1'b0;
`endif

  always @(negedge clk) begin
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (cur_perr) perr_cnt <= perr_cnt + 1;
    if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) wide_cnt <= wide_cnt + 1;
    if ((32'(rx_valid) + 32'(frame_err) + 32'(cur_perr)) > 1) excl_cnt <= excl_cnt + 1;
    prev_valid <= rx_valid;
    prev_ferr  <= frame_err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // par < 0: correct even parity; only sent in the parity build
  task automatic send_frame(input logic [7:0] b, input bit stop, input int hold, input int par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((par < 0) ? ^b : par[0]);
`endif
    drive_bit(stop);
    if (!stop) repeat (hold) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (rx_busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < max), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    int         hold;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, f0, p0, n;

    vecs[0] = '{8'h55, 1'b1, 0,   8'h55, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 0,   8'hA5, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 0,   8'h01, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 0,   8'h80, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 100, 8'h3C, 0, 1};
    vecs[5] = '{8'hC3, 1'b1, 0,   8'hC3, 1, 0};
    vecs[6] = '{8'h00, 1'b1, 0,   8'h00, 1, 0};
    vecs[7] = '{8'hFF, 1'b1, 0,   8'hFF, 1, 0};

    repeat (3) @(negedge clk);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold, -1);
      wait_idle($sformatf("vec%0d idle timeout", i), 60);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d valid pulses", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d frame_err pulses", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d rx_busy", i), 32'(rx_busy), 32'd0);
    end

    // back-to-back frames, no idle gap
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, 0, -1);
    check("b2b first byte", 32'(rx_data), 32'h00);
    send_frame(8'hFF, 1'b1, 0, -1);
    repeat (20) @(negedge clk);
    check("b2b valid pulses", 32'(valid_cnt - v0), 32'd2);
    check("b2b second byte", 32'(rx_data), 32'hFF);

    // start glitch
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    n = 0;
    while (rx_busy == 1'b0 && n < 5) begin @(negedge clk); n++; end
    check("glitch busy seen", 32'(rx_busy), 32'd1);
    n = 0;
    while (rx_busy && n < 30) begin @(negedge clk); n++; end
    check("glitch busy drop within 11", 32'(n <= 11), 32'd1);
    repeat (60) @(negedge clk);
    check("glitch no valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch no frame_err", 32'(ferr_cnt - f0), 32'd0);

    // reset in the middle of an A5 frame
    v0 = valid_cnt; f0 = ferr_cnt;
    fork
      send_frame(8'hA5, 1'b1, 0, -1);
      begin
        repeat (100) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset rx_data", 32'(rx_data), 32'h00);
        check("midreset rx_valid", 32'(rx_valid), 32'd0);
        check("midreset rx_busy", 32'(rx_busy), 32'd0);
      end
    join
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("midreset no partial byte", 32'(valid_cnt - v0), 32'd0);
    check("midreset no frame_err", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'hA5, 1'b1, 0, -1);
    repeat (20) @(negedge clk);
    check("postreset valid", 32'(valid_cnt - v0), 32'd1);
    check("postreset rx_data", 32'(rx_data), 32'hA5);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 0, 1);
    repeat (20) @(negedge clk);
    check("parity good valid", 32'(valid_cnt - v0), 32'd1);
    check("parity good no perr", 32'(perr_cnt - p0), 32'd0);
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 0, 0);
    repeat (20) @(negedge clk);
    check("parity bad no valid", 32'(valid_cnt - v0), 32'd0);
    check("parity bad perr", 32'(perr_cnt - p0), 32'd1);
    check("parity bad rx_data", 32'(rx_data), 32'h07);
`else
    p0 = perr_cnt;
    check("no parity pulses", 32'(p0), 32'd0);
`endif

    check("single-cycle pulses", 32'(wide_cnt), 32'd0);
    check("exclusive pulses", 32'(excl_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
